// File: rtl/shared_ctr_sched_pkg.sv
// Shared types for the shared-counter scheduler: command and FSM encodings,
// plus the width of a requester index.
package shared_ctr_sched_pkg;

   localparam int IDX_W = 1;

   typedef enum logic [1:0] {
      CMD_NOP = 2'b00,
      CMD_INC = 2'b01,
      CMD_DEC = 2'b10,
      CMD_CLR = 2'b11
   } cmd_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/shared_ctr_sched_arb.sv
// Two-input round-robin arbiter: a tie goes to the requester that did not win last.
module rr_arb2
   import shared_ctr_sched_pkg::*;
(
   input  logic [1:0]       req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [1:0]       win_o
);

   always_comb begin
      win_o = 2'b00;
      case (req_i)
         2'b01:   win_o = 2'b01;
         2'b10:   win_o = 2'b10;
         2'b11:   win_o = last_i[0] ? 2'b01 : 2'b10;
         default: win_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/shared_ctr_sched.sv
// Two-requester scheduler owning a saturating up/down counter; one granted
// command per IDLE->GRANT transaction, all outputs registered.
module shared_ctr_sched
   import shared_ctr_sched_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int LIMIT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [1:0]       cmd0,
   input  logic [1:0]       cmd1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [WIDTH-1:0] c,
   output logic             sat
);

   localparam logic [WIDTH:0] LIMIT_X = (WIDTH+1)'(LIMIT);
   localparam logic [WIDTH:0] ONE_X   = (WIDTH+1)'(1);
   localparam logic           SAT_RST = (LIMIT == 0);

   state_t             state_q, state_d;
   logic [1:0]         gnt_q, gnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [WIDTH-1:0]   c_q, c_d;
   logic               sat_q, sat_d;
   logic [1:0]         win;
   cmd_t               cmd_sel;
   logic [WIDTH:0]     c_ext, c_new;

   rr_arb2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .win_o  (win)
   );

   // Extra headroom bit keeps c+1 from wrapping before the clamp compares it.
   always_comb begin
      cmd_sel = cmd_t'(win[1] ? cmd1 : cmd0);
      c_ext   = {1'b0, c_q};
      c_new   = c_ext;
      case (cmd_sel)
         CMD_INC: c_new = (c_ext >= LIMIT_X) ? LIMIT_X : c_ext + ONE_X;
         CMD_DEC: c_new = (c_ext == '0) ? '0 : c_ext - ONE_X;
         CMD_CLR: c_new = '0;
         default: c_new = c_ext;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      gnt_d   = 2'b00;
      last_d  = last_q;
      c_d     = c_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = GRANT;
               gnt_d   = win;
               last_d  = IDX_W'(win[1]);
               c_d     = c_new[WIDTH-1:0];
               sat_d   = (c_new == LIMIT_X);
            end
         end
         GRANT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values,
   // independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         last_q  <= IDX_W'(1);
         c_q     <= '0;
         sat_q   <= SAT_RST;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         c_q     <= c_d;
         sat_q   <= sat_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q == GRANT);
   assign c    = c_q;
   assign sat  = sat_q;

endmodule

// File: tb/tb_shared_ctr_sched.sv
// Directed bench for shared_ctr_sched; inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_shared_ctr_sched;
   import shared_ctr_sched_pkg::*;

   localparam int WIDTH = 11;
   localparam int LIMIT = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req;
   logic [1:0]       cmd0, cmd1;
   logic [1:0]       gnt;
   logic             busy;
   logic [WIDTH-1:0] c;
   logic             sat;

   int checks   = 0;
   int failures = 0;
   int exp_c;

   shared_ctr_sched #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .cmd0 (cmd0),
      .cmd1 (cmd1),
      .gnt  (gnt),
      .busy (busy),
      .c    (c),
      .sat  (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, advance to the grant cycle, then drop req.
   task automatic txn(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1);
      req  = r;
      cmd0 = c0;
      cmd1 = c1;
      tick();
      req  = 2'b00;
   endtask

   task automatic check_out(input string tag, input logic [1:0] g, input logic b,
                            input int cv, input logic s);
      check({tag, ".gnt"},  32'(gnt),  32'(g));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".c"},    32'(c),    32'(cv));
      check({tag, ".sat"},  32'(sat),  32'(s));
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; cmd0 = CMD_NOP; cmd1 = CMD_NOP;
      tick(); tick();
      check_out("reset", 2'b00, 1'b0, 0, 1'b0);

      // Single INC from requester 0.
      rst = 1'b0;
      txn(2'b01, CMD_INC, CMD_NOP);
      check_out("inc1_grant", 2'b01, 1'b1, 1, 1'b0);
      tick();
      check_out("inc1_idle", 2'b00, 1'b0, 1, 1'b0);

      // Bring c to 0, then DEC must clamp at 0.
      txn(2'b10, CMD_NOP, CMD_DEC);
      check_out("dec_to0", 2'b10, 1'b1, 0, 1'b0);
      tick();
      txn(2'b10, CMD_NOP, CMD_DEC);
      check_out("dec_clamp", 2'b10, 1'b1, 0, 1'b0);
      tick();
      check_out("dec_clamp_idle", 2'b00, 1'b0, 0, 1'b0);

      // 205 INCs from requester 1 saturate at LIMIT.
      for (int i = 1; i <= 205; i++) begin
         exp_c = (i < LIMIT) ? i : LIMIT;
         txn(2'b10, CMD_NOP, CMD_INC);
         check("sat_loop.gnt", 32'(gnt), 32'(2'b10));
         check("sat_loop.c",   32'(c),   32'(exp_c));
         check("sat_loop.sat", 32'(sat), 32'(i >= LIMIT));
         tick();
      end
      check_out("sat_hold", 2'b00, 1'b0, LIMIT, 1'b1);

      // Reset, then a continuous tie alternates 0,1,0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_out("reset2", 2'b00, 1'b0, 0, 1'b0);
      req = 2'b11; cmd0 = CMD_INC; cmd1 = CMD_DEC;
      tick();
      check_out("rr_first", 2'b01, 1'b1, 1, 1'b0);
      req = 2'b10;
      tick();
      check_out("rr_gap1", 2'b00, 1'b0, 1, 1'b0);
      req = 2'b11;
      tick();
      check_out("rr_second", 2'b10, 1'b1, 0, 1'b0);
      req = 2'b01;
      tick();
      check_out("rr_gap2", 2'b00, 1'b0, 0, 1'b0);
      req = 2'b11;
      tick();
      check_out("rr_third", 2'b01, 1'b1, 1, 1'b0);
      req = 2'b00;
      tick();

      // c=150 with last winner 0, then NOP(r0) vs CLR(r1) tie.
      for (int i = 0; i < 149; i++) begin
         txn(2'b01, CMD_INC, CMD_NOP);
         tick();
      end
      check_out("preset150", 2'b00, 1'b0, 150, 1'b0);
      req = 2'b11; cmd0 = CMD_NOP; cmd1 = CMD_CLR;
      tick();
      check_out("clr_first", 2'b10, 1'b1, 0, 1'b0);
      req = 2'b01;
      tick();
      tick();
      check_out("nop_second", 2'b01, 1'b1, 0, 1'b0);
      req = 2'b00;
      tick();

      // c=57, INC granted, reset asserted during GRANT.
      for (int i = 0; i < 57; i++) begin
         txn(2'b01, CMD_INC, CMD_NOP);
         tick();
      end
      check("preset57.c", 32'(c), 32'd57);
      txn(2'b01, CMD_INC, CMD_NOP);
      check_out("mid_grant", 2'b01, 1'b1, 58, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_out("mid_reset", 2'b00, 1'b0, 0, 1'b0);
      req = 2'b11; cmd0 = CMD_INC; cmd1 = CMD_INC;
      tick();
      req = 2'b00;
      check_out("post_reset_tie", 2'b01, 1'b1, 1, 1'b0);
      tick();
      check_out("post_reset_idle", 2'b00, 1'b0, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shared_ctr_sched.md
# shared_ctr_sched

Scheduler that shares a single saturating up/down counter between two requesters. Each requester issues a command (increment, decrement, clear, nop) with a req/gnt handshake. A round-robin arbiter picks one command per transaction and applies it to the shared counter. The counter never exceeds LIMIT. The block sits beside the counter datapath, which it owns, and is the only writer of `c`.

## Interface
- `WIDTH`, 11, counter width in bits.
- `LIMIT`, 200, saturation ceiling; must satisfy LIMIT < 2**WIDTH.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 2: per-requester request; bit i belongs to requester i.
- `cmd0` in 2: requester 0 command; 00 NOP, 01 INC, 10 DEC, 11 CLR.
- `cmd1` in 2: requester 1 command, same encoding.
- `gnt` out 2: registered, one-hot grant pulse, at most one bit high.
- `busy` out 1: high while the FSM is in GRANT.
- `c` out WIDTH: shared counter value.
- `sat` out 1: registered, high exactly when `c == LIMIT`.

## Operation
- The FSM has two states, IDLE and GRANT.
- **IDLE:** if `req != 0` at the edge, the FSM goes to GRANT. At that same edge it:
  - sets gnt[w] for the winner w;
  - applies the winner's cmd to c;
  - updates the last-winner register.
  If `req == 0`, it stays in IDLE.
- **GRANT:** the FSM always returns to IDLE on the next edge, and gnt drops to 0. Requests are not evaluated in GRANT.
- **Arbitration:**
  - If exactly one req bit is high, that requester wins.
  - If both are high, the requester that was not the last winner wins.
  - The last-winner register resets to requester 1, so requester 0 wins the first tie.
- **Command effects** (computed at WIDTH+1 bits, then clamped):
  - INC: c+1 if c < LIMIT; otherwise c holds at LIMIT.
  - DEC: c−1 if c > 0; otherwise c holds at 0.
  - CLR: c = 0.
  - NOP: c unchanged, but the request is still granted and still counts toward round-robin.
- **Invariant:** 0 ≤ c ≤ LIMIT in every cycle.
- **sat** is registered alongside c and reflects the new c value.
- **Handshake:**
  - A requester holds req and cmd stable until it sees its gnt bit.
  - It deasserts req at the edge that ends the gnt cycle.
  - A req still high in the next IDLE cycle is treated as a new request.
- **Reset:** `c=0`, `gnt=0`, `busy=0`, `sat=0` (or 1 if LIMIT==0), state=IDLE, last-winner=1.
  - Reset in GRANT aborts the transaction; the reset values win.
  - A command applied at an earlier edge is not undone, but c is cleared by reset anyway.

## Timing
- Request sampled at edge t: gnt, busy, c and sat update at edge t (visible in cycle t+1).
- Grant latency is 1 cycle. gnt is a pulse exactly 1 cycle wide.
- Maximum throughput is one command every 2 cycles. Back-to-back alternating grants are possible when both requesters hold req.
- No combinational path exists from req or cmd to any output.

## Structure
- Package `shared_ctr_sched_pkg` holds:
  - `cmd_t` enum (NOP, INC, DEC, CLR);
  - `state_t` enum (IDLE, GRANT);
  - the requester-index constant width.
- Sub-module `rr_arb2` holds the two-input round-robin arbiter:
  - inputs: req[1:0], last;
  - output: one-hot winner (combinational).
- The top level holds the FSM, command decode, clamp logic and output registers.

## Test plan
- **Reset then single INC:** reset, then req=01, cmd0=INC held until gnt. Required: gnt=01 for one cycle; c=1; busy high for one cycle; sat=0.
- **Saturation:** drive 205 INC transactions from requester 1. Required: c reaches 200 on the 200th grant, then stays 200; sat=1 from that grant onward; c never exceeds 200.
- **Underflow clamp:** from c=0, issue DEC. Required: gnt pulses and c stays 0.
- **Round-robin tie:** after reset, hold req=11 continuously with cmd0=INC and cmd1=DEC, each requester dropping req after its gnt and re-raising it. Required:
  - first grant is 01, then 10, then 01 (alternating);
  - c sequence is 1, 0, 1.
- **CLR and NOP mix:** set c=150, then requester 0 issues NOP and requester 1 issues CLR in a tie with last-winner=0. Required: requester 1 is granted first and c=0; requester 0's NOP is granted next and c stays 0.
- **Reset mid-transaction:** assert rst during the GRANT cycle of an INC from c=57. Required: on the next cycle c=0, gnt=00, busy=0, FSM in IDLE, and the next tie goes to requester 0.
